// File: rtl/mem_pkg.sv
// Shared constants and state type for the vector/scalar memory responder.
// Imported by the responder top and its word store.
package mem_pkg;

  localparam int LANES  = 8;
  localparam int LANE_W = 24;
  localparam int VEC_W  = LANES * LANE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/word_ram.sv
// Single-port word store: synchronous write, asynchronous read.
// Contents are deliberately not touched by reset.
module word_ram #(
  parameter int DEPTH  = 1024,
  parameter int LANE_W = 24,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [LANE_W-1:0] wdata,
  output logic [LANE_W-1:0] rdata
);

  logic [LANE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Request/response front end that walks one word per cycle through
// the store, LANES beats for a vector access and one for a scalar.
module mem_responder
  import mem_pkg::*;
#(
  parameter int LANES  = mem_pkg::LANES,
  parameter int LANE_W = mem_pkg::LANE_W,
  parameter int DEPTH  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic             req_vec,
  input  logic [VEC_W-1:0] req_addr,
  input  logic [VEC_W-1:0] req_wdv,
  input  logic [VEC_W-1:0] req_wds,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [VEC_W-1:0] rsp_rdv,
  output logic [VEC_W-1:0] rsp_rds
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  state_t            state;
  logic [LW-1:0]     beat;
  logic              we_q;
  logic              vec_q;
  logic [AW-1:0]     base_q;
  logic [VEC_W-1:0]  wdv_q;
  logic [LANE_W-1:0] wds_q;
  logic [VEC_W-1:0]  result;

  logic [VEC_W-1:0]  result_nxt;
  logic [LW-1:0]     lane;
  logic [LW-1:0]     last_beat;
  logic              last;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [LANE_W-1:0] ram_wdata;
  logic [LANE_W-1:0] ram_rdata;

  logic unused_bits;
  assign unused_bits = ^{req_addr[VEC_W-1:AW],
                         req_wds[VEC_W-1:LANE_W]};

  assign lane      = vec_q ? beat : '0;
  assign last_beat = vec_q ? LW'(LANES - 1) : '0;
  assign last      = (beat == last_beat);
  assign ram_addr  = base_q + AW'(beat);
  assign ram_wdata = vec_q ? wdv_q[lane*LANE_W +: LANE_W] : wds_q;
  // Reset in the same cycle as a beat must suppress that beat's write.
  assign ram_we    = (state == BUSY) && we_q && !rst;

  always_comb begin
    result_nxt = result;
    if (!we_q) result_nxt[lane*LANE_W +: LANE_W] = ram_rdata;
  end

  word_ram #(
    .DEPTH (DEPTH),
    .LANE_W(LANE_W),
    .AW    (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdv   <= '0;
      rsp_rds   <= '0;
      beat      <= '0;
      result    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            vec_q     <= req_vec;
            base_q    <= req_addr[AW-1:0];
            wdv_q     <= req_wdv;
            wds_q     <= req_wds[LANE_W-1:0];
            beat      <= '0;
            result    <= '0;
            req_ready <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          result <= result_nxt;
          if (last) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdv   <= (vec_q && !we_q) ? result_nxt : '0;
            rsp_rds   <= (!vec_q && !we_q) ?
                         VEC_W'(result_nxt[LANE_W-1:0]) : '0;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdv   <= '0;
            rsp_rds   <= '0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: scalar/vector access, wrap,
// response stall, mid-operation reset and busy-time request masking.
module tb_mem_responder;

  localparam int LW = 24;
  localparam int VW = 192;
  localparam int DP = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic          req_vec;
  logic [VW-1:0] req_addr;
  logic [VW-1:0] req_wdv;
  logic [VW-1:0] req_wds;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [VW-1:0] rsp_rdv;
  logic [VW-1:0] rsp_rds;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_responder #(.LANES(8), .LANE_W(LW), .DEPTH(DP)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_vec  (req_vec),
    .req_addr (req_addr),
    .req_wdv  (req_wdv),
    .req_wds  (req_wds),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdv  (rsp_rdv),
    .rsp_rds  (rsp_rds)
  );

  // Issue one request, wait for the response, then handshake it.
  // lat = cycles from acceptance to first rsp_valid, -1 on timeout.
  task automatic do_req(input logic we, input logic vec,
                        input int addr,
                        input logic [VW-1:0] wdv,
                        input logic [VW-1:0] wds,
                        output int lat,
                        output logic [VW-1:0] rdv,
                        output logic [VW-1:0] rds);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_vec   = vec;
    req_addr  = VW'(addr);
    req_wdv   = wdv;
    req_wds   = wds;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) lat = -1;
    rdv = rsp_rdv;
    rds = rsp_rds;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  function automatic logic [VW-1:0] vec_of(input int base);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i*LW +: LW] = LW'(base + i);
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_vec = 1'b0;
    req_addr = '0;
    req_wdv = '0;
    req_wds = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_req_ready got=%b exp=1", req_ready);
    end
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid);
    end
    n_cmp++;
    if (rsp_rdv !== '0 || rsp_rds !== '0) begin
      n_bad++;
      $display("FAIL reset_data rdv=%h rds=%h exp=0", rsp_rdv, rsp_rds);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_scalar();
    int lat;
    logic [VW-1:0] rdv, rds;
    do_req(1'b1, 1'b0, 5, '0, VW'(24'hABCDEF), lat, rdv, rds);
    n_cmp++;
    if (lat !== 2 || rdv !== '0 || rds !== '0) begin
      n_bad++;
      $display("FAIL scalar_wr lat=%0d rdv=%h rds=%h exp lat=2 ack=0",
               lat, rdv, rds);
    end
    do_req(1'b0, 1'b0, 5, '0, '0, lat, rdv, rds);
    n_cmp++;
    if (lat !== 2) begin
      n_bad++;
      $display("FAIL scalar_rd_lat got=%0d exp=2", lat);
    end
    n_cmp++;
    if (rds !== VW'(24'hABCDEF) || rdv !== '0) begin
      n_bad++;
      $display("FAIL scalar_rd_data rds=%h rdv=%h exp rds=abcdef rdv=0",
               rds, rdv);
    end
  endtask

  task automatic test_vector();
    int lat;
    logic [VW-1:0] rdv, rds;
    do_req(1'b1, 1'b1, 16, vec_of(1), '0, lat, rdv, rds);
    n_cmp++;
    if (lat !== 9 || rdv !== '0 || rds !== '0) begin
      n_bad++;
      $display("FAIL vector_wr lat=%0d rdv=%h rds=%h exp lat=9 ack=0",
               lat, rdv, rds);
    end
    do_req(1'b0, 1'b1, 16, '0, '0, lat, rdv, rds);
    n_cmp++;
    if (lat !== 9) begin
      n_bad++;
      $display("FAIL vector_rd_lat got=%0d exp=9", lat);
    end
    n_cmp++;
    if (rdv !== vec_of(1) || rds !== '0) begin
      n_bad++;
      $display("FAIL vector_rd_data rdv=%h rds=%h exp rdv=%h rds=0",
               rdv, rds, vec_of(1));
    end
    do_req(1'b0, 1'b0, 19, '0, '0, lat, rdv, rds);
    n_cmp++;
    if (rds !== VW'(24'h000004)) begin
      n_bad++;
      $display("FAIL scalar_rd_19 got=%h exp=4", rds);
    end
  endtask

  task automatic test_wrap();
    int lat;
    int a;
    logic [VW-1:0] rdv, rds;
    do_req(1'b1, 1'b1, DP - 3, vec_of(24'h100), '0, lat, rdv, rds);
    for (int i = 0; i < 8; i++) begin
      a = (i < 3) ? (DP - 3 + i) : (i - 3);
      do_req(1'b0, 1'b0, a, '0, '0, lat, rdv, rds);
      n_cmp++;
      if (rds !== VW'(24'h100 + i)) begin
        n_bad++;
        $display("FAIL wrap_word addr=%0d got=%h exp=%h",
                 a, rds, 24'h100 + i);
      end
    end
    do_req(1'b0, 1'b1, DP - 3, '0, '0, lat, rdv, rds);
    n_cmp++;
    if (rdv !== vec_of(24'h100)) begin
      n_bad++;
      $display("FAIL wrap_vec_rd got=%h exp=%h", rdv, vec_of(24'h100));
    end
  endtask

  task automatic test_stall();
    int n;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_vec = 1'b1;
    req_addr = VW'(16);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdv !== vec_of(1) ||
          rsp_rds !== '0 || req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold c=%0d v=%b rr=%b rdv=%h exp v=1 rr=0 rdv=%h",
                 c, rsp_valid, req_ready, rsp_rdv, vec_of(1));
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_release rr=%b v=%b exp rr=1 v=0",
               req_ready, rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [VW-1:0] rdv, rds;
    do_req(1'b1, 1'b1, 32, vec_of(24'h5A0000), '0, lat, rdv, rds);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_vec = 1'b1;
    req_addr = VW'(32);
    req_wdv = vec_of(24'hC00000);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_state rr=%b v=%b exp rr=1 v=0",
               req_ready, rsp_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_no_rsp v=%b exp=0", rsp_valid);
    end
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, 1'b0, 32 + i, '0, '0, lat, rdv, rds);
      n_cmp++;
      if (rds !== VW'((i < 3) ? (24'hC00000 + i) : (24'h5A0000 + i))) begin
        n_bad++;
        $display("FAIL rst_mid_word addr=%0d got=%h", 32 + i, rds);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    logic [VW-1:0] rdv, rds;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_vec = 1'b0;
    req_addr = VW'(50);
    req_wds = VW'(24'h000111);
    @(negedge clk);
    req_addr = VW'(60);
    req_wds = VW'(24'h000222);
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ign_first_rsp v=%b rr=%b exp v=1 rr=0",
               rsp_valid, req_ready);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ign_idle rr=%b exp=1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ign_second_busy v=%b rr=%b exp v=0 rr=0",
               rsp_valid, req_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL ign_second_rsp v=%b exp=1", rsp_valid);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    do_req(1'b0, 1'b0, 50, '0, '0, lat, rdv, rds);
    n_cmp++;
    if (rds !== VW'(24'h000111)) begin
      n_bad++;
      $display("FAIL ign_word50 got=%h exp=111", rds);
    end
    do_req(1'b0, 1'b0, 60, '0, '0, lat, rdv, rds);
    n_cmp++;
    if (rds !== VW'(24'h000222)) begin
      n_bad++;
      $display("FAIL ign_word60 got=%h exp=222", rds);
    end
  endtask

  task automatic test_early_ready();
    int lat;
    logic [VW-1:0] rdv, rds;
    rsp_ready = 1'b1;
    @(negedge clk);
    do_req(1'b0, 1'b0, 5, '0, '0, lat, rdv, rds);
    n_cmp++;
    if (lat !== 2 || rds !== VW'(24'hABCDEF)) begin
      n_bad++;
      $display("FAIL early_ready lat=%0d rds=%h exp lat=2 rds=abcdef",
               lat, rds);
    end
  endtask

  initial begin
    test_reset();
    test_scalar();
    test_vector();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_busy_ignore();
    test_early_ready();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
